// File: rtl/turn_ctrl.sv
// Turn sequencer and score arbiter for Connect-4 Pop: owns the turn, hands moves to the board
// engine, and emits one score pulse per decided round. Optional turn forfeit timer: TURN_TIMEOUT_EN.
module turn_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
    parameter logic        FIRST_PLAYER   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_btn,
    input  logic       p2_btn,
    input  logic [2:0] btn_col,
    input  logic       btn_pop,
    output logic       move_req,
    output logic       move_player,
    output logic       move_pop,
    output logic [2:0] move_col,
    input  logic       move_ack,
    input  logic       move_nack,
    input  logic       chk_done,
    input  logic       chk_win1,
    input  logic       chk_win2,
    input  logic       chk_draw,
    output logic       score_p1,
    output logic       score_p2,
    output logic       turn,
    output logic       round_active,
    output logic       timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MOVE = 3'd1,
        ISSUE     = 3'd2,
        CHECK     = 3'd3,
        SCORE     = 3'd4,
        ROUND_END = 3'd5
    } state_t;

    state_t st;
    logic   first;
    logic   commit;
    logic   mover_win;
    logic   opp_win;
    logic   winner_p2;

    assign state = st;

    always_comb begin
        commit    = (st == WAIT_MOVE) && (turn ? p2_btn : p1_btn) && (btn_col <= 3'd6);
        mover_win = move_player ? chk_win2 : chk_win1;
        opp_win   = move_player ? chk_win1 : chk_win2;
        // A pop completing both lines still goes to the mover.
        winner_p2 = mover_win ? move_player : ~move_player;
    end

`ifdef TURN_TIMEOUT_EN
    logic [31:0] timer;
    logic        expire;
    always_comb expire = (st == WAIT_MOVE) && (timer == TIMEOUT_CYCLES - 32'd1);
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            st           <= IDLE;
            turn         <= FIRST_PLAYER;
            first        <= FIRST_PLAYER;
            move_req     <= 1'b0;
            move_col     <= 3'd0;
            move_pop     <= 1'b0;
            move_player  <= 1'b0;
            score_p1     <= 1'b0;
            score_p2     <= 1'b0;
            round_active <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            timeout      <= 1'b0;
            timer        <= 32'd0;
`endif
        end else begin
            score_p1 <= 1'b0;
            score_p2 <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            case (st)
                IDLE: begin
                    turn <= first;
                    if (start) begin
                        st           <= WAIT_MOVE;
                        round_active <= 1'b1;
`ifdef TURN_TIMEOUT_EN
                        timer        <= 32'd0;
`endif
                    end
                end
                WAIT_MOVE: begin
                    if (commit) begin
                        move_col    <= btn_col;
                        move_pop    <= btn_pop;
                        move_player <= turn;
                        move_req    <= 1'b1;
                        st          <= ISSUE;
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (expire) begin
                        timeout <= 1'b1;
                        turn    <= ~turn;
                        timer   <= 32'd0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
`endif
                end
                ISSUE: begin
                    if (move_nack) begin
                        move_req <= 1'b0;
                        st       <= WAIT_MOVE;
                    end else if (move_ack) begin
                        move_req <= 1'b0;
                        st       <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk_done) begin
                        if (mover_win || opp_win) begin
                            st <= SCORE;
                            if (winner_p2) score_p2 <= 1'b1;
                            else           score_p1 <= 1'b1;
                        end else if (chk_draw) begin
                            st           <= ROUND_END;
                            round_active <= 1'b0;
                            first        <= ~first;
                        end else begin
                            st   <= WAIT_MOVE;
                            turn <= ~turn;
`ifdef TURN_TIMEOUT_EN
                            timer <= 32'd0;
`endif
                        end
                    end
                end
                SCORE: begin
                    st           <= ROUND_END;
                    round_active <= 1'b0;
                    first        <= ~first;
                end
                ROUND_END: begin
                    if (start) begin
                        st           <= WAIT_MOVE;
                        turn         <= first;
                        round_active <= 1'b1;
`ifdef TURN_TIMEOUT_EN
                        timer        <= 32'd0;
`endif
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
